// File: rtl/poly_basemul.sv
// poly_basemul: ML-KEM-768 pointwise multiply of two NTT-domain polynomials.
// Coefficients stream in one pair per accepted cycle. Each degree-1 pair (a0 + a1 X)(b0 + b1 X)
// mod (X^2 - zeta) is reduced in Montgomery form through a fixed-latency pipeline. The 256-entry
// product streams out in coefficient order.
module poly_basemul (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_ready,
   input  logic signed [15:0] i_a,
   input  logic signed [15:0] i_b,
   output logic               o_valid,
   output logic signed [15:0] o_data,
   output logic               o_last
);

   localparam int KYBER_Q = 3329;
   localparam int QINV    = -3327;
   localparam int N       = 256;

   localparam logic [15:0] QINV16   = 16'(QINV);
   localparam logic [7:0]  LAST_IDX = 8'(N - 1);

   // Upper half (entries 64..127) of the Montgomery-form zeta table shared with the ntt stage
   localparam logic signed [15:0] ZETAS [64] = '{
      -16'sd1103,  16'sd430,    16'sd555,    16'sd843,   -16'sd1251,  16'sd871,    16'sd1550,
       16'sd105,   16'sd422,    16'sd587,    16'sd177,   -16'sd235,  -16'sd291,   -16'sd460,
       16'sd1574,  16'sd1653,  -16'sd246,    16'sd778,    16'sd1159, -16'sd147,   -16'sd777,
       16'sd1483, -16'sd602,    16'sd1119,  -16'sd1590,   16'sd644,  -16'sd872,    16'sd349,
       16'sd418,   16'sd329,   -16'sd156,   -16'sd75,     16'sd817,   16'sd1097,   16'sd603,
       16'sd610,   16'sd1322,  -16'sd1285,  -16'sd1465,   16'sd384,  -16'sd1215,  -16'sd136,
       16'sd1218, -16'sd1335,  -16'sd874,    16'sd220,   -16'sd1187, -16'sd1659,  -16'sd1185,
      -16'sd1530, -16'sd1278,   16'sd794,   -16'sd1510,  -16'sd854,  -16'sd870,    16'sd478,
      -16'sd108,  -16'sd308,    16'sd996,    16'sd991,    16'sd958,  -16'sd1460,   16'sd1522,
       16'sd1628
   };

   // Montgomery reduction: returns p * 2^-16 mod q with |result| < q for |p| < q * 2^15
   function automatic logic signed [15:0] mont_reduce(input logic signed [31:0] p);
      logic [15:0]        t_u;
      logic signed [15:0] t;
      logic signed [31:0] d;
      t_u = p[15:0] * QINV16;
      t   = signed'(t_u);
      // d is an exact multiple of 2^16, so taking the upper half is the arithmetic shift
      d   = p - 32'(t) * 32'(KYBER_Q);
      return d[31:16];
   endfunction

   logic [7:0]         n_in_q;
   logic [7:0]         n_out_q;
   logic signed [15:0] a0_q, b0_q;
   logic               s1_v_q, s2_v_q, s3_v_q, s4_v_q, skid_v_q;
   logic signed [31:0] p11_q, p00_q, p01_q, p10_q;
   logic signed [15:0] s1_zeta_q, s2_zeta_q;
   logic signed [15:0] m11_q, m00_q, m01_q, m10_q;
   logic signed [31:0] pz_q;
   logic signed [15:0] s3_m00_q, s3_m01_q, s3_m10_q;
   logic signed [15:0] r0_q, r1_q, skid_q;
   logic               accept_odd;
   logic               emit;
   logic signed [15:0] zeta_d;

   // Pair launch strobe, zeta selection for pair k = n_in>>1, and output-slot occupancy
   always_comb begin
      accept_odd = i_ready & n_in_q[0];
      zeta_d     = n_in_q[1] ? -ZETAS[n_in_q[7:2]] : ZETAS[n_in_q[7:2]];
      emit       = s4_v_q | skid_v_q;
   end

   // Control: indices, pipeline valids and the registered output port
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         n_in_q   <= '0;
         n_out_q  <= '0;
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s3_v_q   <= 1'b0;
         s4_v_q   <= 1'b0;
         skid_v_q <= 1'b0;
         o_valid  <= 1'b0;
         o_last   <= 1'b0;
         o_data   <= '0;
      end else begin
         if (i_ready) begin
            n_in_q <= n_in_q + 8'd1;
         end
         s1_v_q  <= accept_odd;
         s2_v_q  <= s1_v_q;
         s3_v_q  <= s2_v_q;
         s4_v_q  <= s3_v_q;
         o_valid <= emit;
         o_last  <= emit && (n_out_q == LAST_IDX);
         if (emit) begin
            n_out_q <= n_out_q + 8'd1;
         end
         // r0 goes out first; r1 waits one cycle in the skid slot, which is always free
         // because the next pair reaches stage 4 no earlier than two cycles later
         if (s4_v_q) begin
            o_data   <= r0_q;
            skid_v_q <= 1'b1;
         end else if (skid_v_q) begin
            o_data   <= skid_q;
            skid_v_q <= 1'b0;
         end
      end
   end

   // Datapath: even-coefficient buffer and the four arithmetic stages, enabled by their valids
   always_ff @(posedge i_clk) begin
      if (i_ready && !n_in_q[0]) begin
         a0_q <= i_a;
         b0_q <= i_b;
      end
      // Stage 1: the four cross products
      if (accept_odd) begin
         p11_q     <= 32'(i_a) * 32'(i_b);
         p00_q     <= 32'(a0_q) * 32'(b0_q);
         p01_q     <= 32'(a0_q) * 32'(i_b);
         p10_q     <= 32'(i_a) * 32'(b0_q);
         s1_zeta_q <= zeta_d;
      end
      // Stage 2: Montgomery reduce
      if (s1_v_q) begin
         m11_q     <= mont_reduce(p11_q);
         m00_q     <= mont_reduce(p00_q);
         m01_q     <= mont_reduce(p01_q);
         m10_q     <= mont_reduce(p10_q);
         s2_zeta_q <= s1_zeta_q;
      end
      // Stage 3: multiply a1*b1 term by zeta
      if (s2_v_q) begin
         pz_q     <= 32'(m11_q) * 32'(s2_zeta_q);
         s3_m00_q <= m00_q;
         s3_m01_q <= m01_q;
         s3_m10_q <= m10_q;
      end
      // Stage 4: reduce the zeta product and form the unreduced sums
      if (s3_v_q) begin
         r0_q <= mont_reduce(pz_q) + s3_m00_q;
         r1_q <= s3_m01_q + s3_m10_q;
      end
      if (s4_v_q) begin
         skid_q <= r1_q;
      end
   end

endmodule

// File: doc/poly_basemul.md
Name: poly_basemul

Overview:
Pointwise polynomial multiplier for ML-KEM-768 in the NTT domain. It sits directly downstream of the forward ntt stage. The top-level sequencer streams two NTT-domain polynomials a and b into it, one coefficient pair per cycle. For each degree-1 pair it computes the Kyber basemul in Montgomery form and streams the 256-coefficient product out, which then feeds the inverse ntt (i_intt=1).

Parameters:
KYBER_Q, 3329, modulus
QINV, -3327, q^-1 mod 2^16 as a signed 16-bit value
N, 256, coefficients per polynomial

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_ready  input  1  input strobe: i_a/i_b accepted this cycle
i_a  input  16 signed  coefficient a[n], NTT domain, |a|<q
i_b  input  16 signed  coefficient b[n], NTT domain, |b|<q
o_valid  output  1  o_data holds a valid product coefficient
o_data  output  16 signed  product coefficient r[n]
o_last  output  1  high with o_valid on coefficient 255

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_valid=0, o_last=0, o_data=0. The input index, output index and all pipeline valid bits clear to 0.
- Input index n_in is 8 bits. It increments on every i_ready cycle and wraps 255→0, so back-to-back frames need no gap.
- i_ready may drop at any cycle (stall); index and buffered data hold while it is low.
- Even index (n_in[0]=0): latch a0=i_a and b0=i_b. Odd index: a1=i_a, b1=i_b, pair k=n_in>>1 (0..127) launches into the pipeline.
- fqmul(x,y): p = x*y (32-bit signed); t = low 16 bits of p*QINV, taken as signed; result = (p - t*KYBER_Q) >>> 16, giving |result|<q.
- zeta(k) = +zetas[64+k/2] for even k, -zetas[64+k/2] for odd k. zetas[] is the Montgomery-form zeta ROM content already used by ntt (zetas[64]=-1103). Implement it as a 64-entry signed 16-bit ROM.
- r0 = fqmul(fqmul(a1,b1), zeta(k)) + fqmul(a0,b0).
- r1 = fqmul(a0,b1) + fqmul(a1,b0).
- Sums are not reduced: each is in (-2q,2q) and fits signed 16-bit. This matches the C reference bit-exactly.
- Pipeline is fixed latency and fully pipelined, accepting a new pair every 2 accepted inputs with no backpressure.
  - Stage 1: four products a1*b1, a0*b0, a0*b1, a1*b0.
  - Stage 2: Montgomery reduce.
  - Stage 3: zeta product.
  - Stage 4: reduce, then the r0/r1 adds.
- Latency: with odd coefficient 2k+1 accepted at cycle T, o_data=r[2k] with o_valid=1 at T+4, and o_data=r[2k+1] with o_valid=1 at T+5.
- Under a full-rate stream, output is therefore continuous after the first 5 cycles.
- r1 of pair k must stay held in an output skid register so that its T+5 slot cannot collide with the next pair. The next pair's earliest T' is T+2, so its r0 is emitted at T+6.
- Output index n_out is 8 bits, increments on each o_valid and wraps 255→0. o_last = o_valid && n_out==255.
- o_valid deasserts on any cycle with no product to emit. o_data holds its last value when o_valid=0.
- A partial frame (i_ready drops after an even index) holds a0/b0 indefinitely. No output is produced for that pair until its odd coefficient arrives.
- Reset mid-frame discards all in-flight pairs. No o_valid occurs in the cycle after the reset cycle. The next accepted input is index 0.

Test Plan:
- Identity: pair0 a=(2285,0), b=(7,0), remaining coefficients 0, full-rate 256 cycles → r[0]=7, r[1]=0, all other r=0. o_valid first seen 4 cycles after the 2nd input. o_last on the 256th output.
- Cross term: pair0 a=(2285,0), b=(0,5) → r[0]=0, r[1]=5.
- Zeta sign: pairs 0 and 1 both a=(0,2285), b=(0,2285) → r[0]=-1103, r[1]=0, r[2]=+1103, r[3]=0.
- Montgomery scaling: a=(1,0), b=(1,0) in pair 0 → r[0]=169.
- Stall: same stimulus as Identity, with i_ready low for 3 cycles between index 0 and index 1 → r[0]=7 at 4 cycles after index 1 is accepted. No spurious o_valid during the stall.
- Random golden compare: 3 back-to-back frames of random |coef|<q against the C poly_basemul_montgomery model → bit-exact match, continuous o_valid, o_last every 256 outputs.
- Reset mid-frame: assert i_rst at input 100, then send a fresh Identity frame → the first o_valid carries 7. Outputs total exactly 256.
